// File: rtl/mem1r2w_arb_pkg.sv
// Shared defaults and the holding-entry record for the two-writer, one-reader memory.
package mem1r2w_arb_pkg;
   localparam int unsigned ADDRBIT_DEF = 9;
   localparam int unsigned DEPTH_DEF   = 512;
   localparam int unsigned WIDTH_DEF   = 32;

   typedef struct packed {
      logic [ADDRBIT_DEF-1:0] addr;
      logic [WIDTH_DEF-1:0]   data;
      logic                   full;
   } hold_t;
endpackage

// File: rtl/mem1r2w_arb_if.sv
// Bus bundle for mem1r2w_arb: two write handshakes, one registered read port, busy.
interface mem1r2w_arb_if import mem1r2w_arb_pkg::*; #(
   parameter int unsigned ADDRBIT = ADDRBIT_DEF,
   parameter int unsigned WIDTH   = WIDTH_DEF
);
   logic [ADDRBIT-1:0] wa1, wa2, ra;
   logic [WIDTH-1:0]   wd1, wd2, dout;
   logic               wv1, wv2, wr1, wr2, re, dv, busy;

   modport slave (
      input  wa1, wd1, wv1, wa2, wd2, wv2, ra, re,
      output wr1, wr2, dout, dv, busy
   );

   modport master (
      output wa1, wd1, wv1, wa2, wd2, wv2, ra, re,
      input  wr1, wr2, dout, dv, busy
   );
endinterface

// File: rtl/mem1r2w_rrarb.sv
// Two-request round-robin arbiter; rr points at the port not granted last.
module mem1r2w_rrarb (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);
   logic rr_q, rr_d;

   always_comb begin
      gnt = req;
      if (req == 2'b11) gnt = rr_q ? 2'b10 : 2'b01;
      rr_d = rr_q;
      if (gnt[0])      rr_d = 1'b1;
      else if (gnt[1]) rr_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rr_q <= 1'b0;
      else     rr_q <= rr_d;
   end
endmodule

// File: rtl/mem1r2w_arb.sv
// 1R2W memory: two writers share the array write port via holding registers and
// a round-robin arbiter; one registered, write-first read port.
module mem1r2w_arb import mem1r2w_arb_pkg::*; #(
   parameter int unsigned ADDRBIT = ADDRBIT_DEF,
   parameter int unsigned DEPTH   = DEPTH_DEF,
   parameter int unsigned WIDTH   = WIDTH_DEF
) (
   input  logic          clk,
   input  logic          rst,
   mem1r2w_arb_if.slave  bus
);
   typedef struct packed {
      logic [ADDRBIT-1:0] addr;
      logic [WIDTH-1:0]   data;
      logic               full;
   } entry_t;

   localparam logic [ADDRBIT:0] DEPTH_W = (ADDRBIT+1)'(DEPTH);

   entry_t             h1_q, h1_d, h2_q, h2_d;
   logic [1:0]         gnt;
   logic               wr1, wr2, commit, commit_ok, rd_ok;
   logic [ADDRBIT-1:0] commit_addr;
   logic [WIDTH-1:0]   commit_data, dout_q, dout_d;
   logic               dv_q, dv_d;
   logic [WIDTH-1:0]   mem [DEPTH];

   mem1r2w_rrarb u_arb (
      .clk (clk),
      .rst (rst),
      .req ({h2_q.full, h1_q.full}),
      .gnt (gnt)
   );

   always_comb begin
      // A granted entry drains this cycle, so its slot can be refilled on the same edge.
      wr1 = ~rst & (~h1_q.full | gnt[0]);
      wr2 = ~rst & (~h2_q.full | gnt[1]);

      commit      = |gnt;
      commit_addr = gnt[1] ? h2_q.addr : h1_q.addr;
      commit_data = gnt[1] ? h2_q.data : h1_q.data;
      commit_ok   = commit && ({1'b0, commit_addr} < DEPTH_W);
      rd_ok       = {1'b0, bus.ra} < DEPTH_W;

      h1_d = h1_q;
      if (gnt[0]) h1_d.full = 1'b0;
      if (bus.wv1 && wr1) h1_d = '{addr: bus.wa1, data: bus.wd1, full: 1'b1};

      h2_d = h2_q;
      if (gnt[1]) h2_d.full = 1'b0;
      if (bus.wv2 && wr2) h2_d = '{addr: bus.wa2, data: bus.wd2, full: 1'b1};

      dv_d   = bus.re;
      dout_d = dout_q;
      if (bus.re) begin
         if (!rd_ok)                              dout_d = '0;
         else if (commit && commit_addr == bus.ra) dout_d = commit_data;
         else                                     dout_d = mem[bus.ra];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h1_q   <= '0;
         h2_q   <= '0;
         dout_q <= '0;
         dv_q   <= 1'b0;
      end else begin
         h1_q   <= h1_d;
         h2_q   <= h2_d;
         dout_q <= dout_d;
         dv_q   <= dv_d;
      end
   end

   // Array contents survive reset; out-of-range commits are dropped.
   always_ff @(posedge clk) begin
      if (commit_ok) mem[commit_addr] <= commit_data;
   end

   assign bus.wr1  = wr1;
   assign bus.wr2  = wr2;
   assign bus.dout = dout_q;
   assign bus.dv   = dv_q;
   assign bus.busy = h1_q.full | h2_q.full;
endmodule

// File: tb/tb_mem1r2w_arb.sv
// Directed self-checking bench for mem1r2w_arb.
module tb_mem1r2w_arb;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   mem1r2w_arb_if #(.ADDRBIT(9), .WIDTH(32)) bus ();

   mem1r2w_arb #(.ADDRBIT(9), .DEPTH(512), .WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      bus.wa1 = '0; bus.wd1 = '0; bus.wv1 = 1'b0;
      bus.wa2 = '0; bus.wd2 = '0; bus.wv2 = 1'b0;
      bus.ra  = '0; bus.re  = 1'b0;
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic wr_port(input int p, input logic [8:0] a, input logic [31:0] d);
      bit ok;
      ok = 1'b0;
      if (p == 1) begin bus.wa1 = a; bus.wd1 = d; bus.wv1 = 1'b1; end
      else        begin bus.wa2 = a; bus.wd2 = d; bus.wv2 = 1'b1; end
      for (int i = 0; i < 8 && !ok; i++) begin
         ok = (p == 1) ? bus.wr1 : bus.wr2;
         @(negedge clk);
      end
      bus.wv1 = 1'b0;
      bus.wv2 = 1'b0;
      if (!ok) begin
         n_checks++;
         $display("FAIL wr_port%0d_timeout: wr stayed 0, required 1", p);
      end
   endtask

   task automatic drain();
      int i;
      for (i = 0; i < 8 && bus.busy; i++) @(negedge clk);
      if (bus.busy) begin
         n_checks++;
         $display("FAIL drain_timeout: busy=%0b, required 0", bus.busy);
      end
   endtask

   task automatic rd(input logic [8:0] a, output logic [31:0] d, output logic v);
      bus.ra = a;
      bus.re = 1'b1;
      @(negedge clk);
      d = bus.dout;
      v = bus.dv;
      bus.re = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic        v;
      @(negedge clk);
      n_checks++; if ({bus.dout, bus.dv, bus.busy, bus.wr1, bus.wr2} !== 36'h0)
         $display("FAIL reset_init: dout=%h dv=%b busy=%b wr=%b%b, required all 0", bus.dout, bus.dv, bus.busy, bus.wr1, bus.wr2);
      else n_pass++;
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if ({bus.wr1, bus.wr2} !== 2'b11)
         $display("FAIL reset_release_wr: wr1wr2=%b%b, required 11", bus.wr1, bus.wr2);
      else n_pass++;
      // Build up state: dout non-zero and a held entry, then reset mid-cycle.
      wr_port(1, 9'd40, 32'hCAFE_0001);
      bus.ra = 9'd40; bus.re = 1'b1;
      bus.wa1 = 9'd41; bus.wd1 = 32'h0BAD_0041; bus.wv1 = 1'b1;
      @(negedge clk);
      bus.re = 1'b0; bus.wv1 = 1'b0;
      n_checks++; if (bus.dout !== 32'hCAFE_0001 || bus.dv !== 1'b1 || bus.busy !== 1'b1)
         $display("FAIL pre_reset_state: dout=%h dv=%b busy=%b, required cafe0001 1 1", bus.dout, bus.dv, bus.busy);
      else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_checks++; if ({bus.dout, bus.dv, bus.busy, bus.wr1, bus.wr2} !== 36'h0)
         $display("FAIL reset_midrun: dout=%h dv=%b busy=%b wr=%b%b, required all 0", bus.dout, bus.dv, bus.busy, bus.wr1, bus.wr2);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if ({bus.wr1, bus.wr2} !== 2'b11)
         $display("FAIL reset_midrun_release_wr: wr1wr2=%b%b, required 11", bus.wr1, bus.wr2);
      else n_pass++;
      rd(9'd40, d, v);
      n_checks++; if (d !== 32'hCAFE_0001 || v !== 1'b1)
         $display("FAIL array_kept_over_reset: data=%h dv=%b, required cafe0001 1", d, v);
      else n_pass++;
   endtask

   task automatic test_single_write();
      bus.wa1 = 9'd5; bus.wd1 = 32'hA5A5_A5A5; bus.wv1 = 1'b1;
      n_checks++; if (bus.wr1 !== 1'b1)
         $display("FAIL single_wr1_ready: wr1=%b, required 1", bus.wr1);
      else n_pass++;
      @(negedge clk);
      bus.wv1 = 1'b0;
      bus.ra = 9'd5; bus.re = 1'b1;
      @(negedge clk);
      bus.re = 1'b0;
      n_checks++; if (bus.dout !== 32'hA5A5_A5A5 || bus.dv !== 1'b1)
         $display("FAIL single_raw_read: dout=%h dv=%b, required a5a5a5a5 1", bus.dout, bus.dv);
      else n_pass++;
      @(negedge clk);
      n_checks++; if (bus.dout !== 32'hA5A5_A5A5 || bus.dv !== 1'b0)
         $display("FAIL single_hold: dout=%h dv=%b, required a5a5a5a5 0", bus.dout, bus.dv);
      else n_pass++;
   endtask

   task automatic test_collision();
      logic [31:0] d;
      logic        v;
      reset_pulse();
      bus.wa1 = 9'd3; bus.wd1 = 32'd1; bus.wv1 = 1'b1;
      bus.wa2 = 9'd3; bus.wd2 = 32'd2; bus.wv2 = 1'b1;
      n_checks++; if ({bus.wr1, bus.wr2} !== 2'b11)
         $display("FAIL coll_both_ready: wr1wr2=%b%b, required 11", bus.wr1, bus.wr2);
      else n_pass++;
      @(negedge clk);
      bus.wv1 = 1'b0; bus.wv2 = 1'b0;
      n_checks++; if ({bus.wr1, bus.wr2} !== 2'b10)
         $display("FAIL coll_t1_ready: wr1wr2=%b%b, required 10", bus.wr1, bus.wr2);
      else n_pass++;
      bus.ra = 9'd3; bus.re = 1'b1;
      @(negedge clk);
      n_checks++; if (bus.dout !== 32'd1 || bus.busy !== 1'b1)
         $display("FAIL coll_p1_commit_t1: dout=%h busy=%b, required 00000001 1", bus.dout, bus.busy);
      else n_pass++;
      @(negedge clk);
      bus.re = 1'b0;
      n_checks++; if (bus.dout !== 32'd2 || bus.busy !== 1'b0)
         $display("FAIL coll_p2_commit_t2: dout=%h busy=%b, required 00000002 0", bus.dout, bus.busy);
      else n_pass++;
      rd(9'd3, d, v);
      n_checks++; if (d !== 32'd2)
         $display("FAIL coll_last_wins: data=%h, required 00000002", d);
      else n_pass++;
   endtask

   task automatic test_streaming();
      int n1, n2;
      logic [31:0] d;
      logic        v;
      n1 = 0; n2 = 0;
      reset_pulse();
      for (int c = 0; c < 30 && (n1 + n2) < 16; c++) begin
         bus.wv1 = (n1 < 8); bus.wa1 = 9'(2 * n1);     bus.wd1 = 32'h1000_0000 | 32'(2 * n1);
         bus.wv2 = (n2 < 8); bus.wa2 = 9'(2 * n2 + 1); bus.wd2 = 32'h2000_0000 | 32'(2 * n2 + 1);
         // Cycle 0 both idle; afterwards port 1 gets odd cycles, port 2 even ones.
         if (c >= 1) begin
            n_checks++; if ({bus.wr1, bus.wr2} !== ((c % 2 == 1) ? 2'b10 : 2'b01))
               $display("FAIL stream_alt_c%0d: wr1wr2=%b%b, required %s", c, bus.wr1, bus.wr2, (c % 2 == 1) ? "10" : "01");
            else n_pass++;
         end
         if (bus.wv1 && bus.wr1) n1++;
         if (bus.wv2 && bus.wr2) n2++;
         @(negedge clk);
      end
      bus.wv1 = 1'b0; bus.wv2 = 1'b0;
      n_checks++; if (n1 + n2 !== 16)
         $display("FAIL stream_accepts: accepts=%0d, required 16", n1 + n2);
      else n_pass++;
      drain();
      for (int a = 0; a < 16; a++) begin
         rd(9'(a), d, v);
         n_checks++; if (d !== (((a % 2) == 0 ? 32'h1000_0000 : 32'h2000_0000) | 32'(a)))
            $display("FAIL stream_readback_%0d: data=%h, required %h", a, d, ((a % 2) == 0 ? 32'h1000_0000 : 32'h2000_0000) | 32'(a));
         else n_pass++;
      end
   endtask

   task automatic test_reset_pending();
      logic [31:0] d;
      logic        v;
      reset_pulse();
      wr_port(2, 9'd7, 32'h0000_0077);
      drain();
      bus.wa1 = 9'd9; bus.wd1 = 32'h0000_0099; bus.wv1 = 1'b1;
      bus.wa2 = 9'd7; bus.wd2 = 32'hDEAD_7777; bus.wv2 = 1'b1;
      @(negedge clk);
      bus.wv1 = 1'b0; bus.wv2 = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.busy !== 1'b1)
         $display("FAIL pend_busy_before: busy=%b, required 1", bus.busy);
      else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_checks++; if (bus.busy !== 1'b0 || bus.wr2 !== 1'b0)
         $display("FAIL pend_reset_busy: busy=%b wr2=%b, required 0 0", bus.busy, bus.wr2);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rd(9'd7, d, v);
      n_checks++; if (d !== 32'h0000_0077)
         $display("FAIL pend_addr7_kept: data=%h, required 00000077", d);
      else n_pass++;
      rd(9'd9, d, v);
      n_checks++; if (d !== 32'h0000_0099)
         $display("FAIL pend_addr9_committed: data=%h, required 00000099", d);
      else n_pass++;
   endtask

   task automatic test_read_contention();
      wr_port(1, 9'd20, 32'h0000_0011);
      wr_port(1, 9'd21, 32'h0000_0022);
      drain();
      reset_pulse();
      bus.wa1 = 9'd20; bus.wd1 = 32'h0000_AAAA; bus.wv1 = 1'b1;
      bus.wa2 = 9'd21; bus.wd2 = 32'h0000_BBBB; bus.wv2 = 1'b1;
      bus.ra = 9'd21; bus.re = 1'b1;
      @(negedge clk);
      bus.wv1 = 1'b0; bus.wv2 = 1'b0;
      n_checks++; if (bus.dv !== 1'b1 || bus.dout !== 32'h0000_0022)
         $display("FAIL cont_rd_accept_cycle: dout=%h dv=%b, required 00000022 1", bus.dout, bus.dv);
      else n_pass++;
      @(negedge clk);
      n_checks++; if (bus.dv !== 1'b1 || bus.dout !== 32'h0000_0022)
         $display("FAIL cont_rd_held_invisible: dout=%h dv=%b, required 00000022 1", bus.dout, bus.dv);
      else n_pass++;
      bus.ra = 9'd20;
      @(negedge clk);
      n_checks++; if (bus.dv !== 1'b1 || bus.dout !== 32'h0000_AAAA)
         $display("FAIL cont_rd_p1_committed: dout=%h dv=%b, required 0000aaaa 1", bus.dout, bus.dv);
      else n_pass++;
      bus.ra = 9'd21;
      @(negedge clk);
      bus.re = 1'b0;
      n_checks++; if (bus.dv !== 1'b1 || bus.dout !== 32'h0000_BBBB)
         $display("FAIL cont_rd_p2_committed: dout=%h dv=%b, required 0000bbbb 1", bus.dout, bus.dv);
      else n_pass++;
      @(negedge clk);
      n_checks++; if (bus.dv !== 1'b0 || bus.dout !== 32'h0000_BBBB)
         $display("FAIL cont_dv_drop: dout=%h dv=%b, required 0000bbbb 0", bus.dout, bus.dv);
      else n_pass++;
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single_write();
      test_collision();
      test_streaming();
      test_reset_pending();
      test_read_contention();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
